vlsu_ar_splitter: RTL and testbench

- Sits between the VLSU address generator's AR output (downstream of the AXI cut's slave side) and the AXI read channel.
- Splits each INCR read burst into sub-bursts that never exceed MaxBeats and never cross a 4 KiB page.
- On the R channel it suppresses every RLAST except the one closing the final sub-burst, so the load unit sees exactly one burst per request.
- Single AXI ID; responses are in order.

---
 rtl/vlsu_ar_splitter.sv | 160 ++++++++++++++++
 tb/tb_vlsu_ar_splitter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vlsu_ar_splitter.sv
// Splits INCR AR bursts into sub-bursts bounded by MaxBeats and 4 KiB pages; masks RLAST on non-final sub-bursts.
// Define VLSU_AR_SPLIT_STATS_EN to add the nr_split_o counter of requests that were split.
module vlsu_ar_splitter #(
   parameter int unsigned AxiAddrWidth  = 64,
   parameter int unsigned AxiDataWidth  = 128,
   parameter int unsigned MaxBeats      = 16,
   parameter int unsigned NrOutstanding = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [AxiAddrWidth-1:0] slv_ar_addr_i,
   input  logic [7:0]              slv_ar_len_i,
   input  logic [2:0]              slv_ar_size_i,
   input  logic [1:0]              slv_ar_burst_i,
   input  logic                    slv_ar_valid_i,
   output logic                    slv_ar_ready_o,
   output logic [AxiAddrWidth-1:0] mst_ar_addr_o,
   output logic [7:0]              mst_ar_len_o,
   output logic [2:0]              mst_ar_size_o,
   output logic [1:0]              mst_ar_burst_o,
   output logic                    mst_ar_valid_o,
   input  logic                    mst_ar_ready_i,
   input  logic [AxiDataWidth-1:0] mst_r_data_i,
   input  logic [1:0]              mst_r_resp_i,
   input  logic                    mst_r_last_i,
   input  logic                    mst_r_valid_i,
   output logic                    mst_r_ready_o,
   output logic [AxiDataWidth-1:0] slv_r_data_o,
   output logic [1:0]              slv_r_resp_o,
   output logic                    slv_r_last_o,
   output logic                    slv_r_valid_o,
`ifdef VLSU_AR_SPLIT_STATS_EN
   output logic [31:0]             nr_split_o,
`endif
   input  logic                    slv_r_ready_i
);

   localparam int unsigned PtrW      = $clog2(NrOutstanding);
   localparam logic [PtrW:0] Depth   = (PtrW+1)'(NrOutstanding);
   localparam logic [12:0] MaxBeatsL = 13'(MaxBeats);
   localparam logic [1:0] BurstIncr  = 2'd1;

   typedef enum logic {IDLE, SPLIT} state_e;

   state_e                  state_q;
   logic [AxiAddrWidth-1:0] addr_q;
   logic [2:0]              size_q;
   logic [1:0]              burst_q;
   logic [8:0]              beats_left_q;

   logic [NrOutstanding-1:0] final_q;
   logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]            count_q;

   logic full, empty, push, pop, slv_ar_hs, is_final;
   logic [12:0] page_beats, n_incr;
   logic [8:0]  n;
   logic [AxiAddrWidth-1:0] next_addr;

   // NOTE: always_comb uses blocking assignments and assigns every output first, so no latch is inferred.
   always_comb begin
      page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> size_q;
      if (page_beats == 13'd0) page_beats = 13'd1;
      n_incr = {4'd0, beats_left_q};
      if (MaxBeatsL < n_incr) n_incr = MaxBeatsL;
      if (page_beats < n_incr) n_incr = page_beats;
      n = (burst_q == BurstIncr) ? n_incr[8:0] : beats_left_q;
   end

   // An unaligned start address is aligned down before advancing, so later sub-bursts start aligned.
   assign next_addr = ((addr_q >> size_q) << size_q) + (AxiAddrWidth'(n) << size_q);
   assign is_final  = (beats_left_q == n);

   assign full      = (count_q == Depth);
   assign empty     = (count_q == '0);
   assign slv_ar_hs = slv_ar_valid_i && slv_ar_ready_o;
   assign push      = mst_ar_valid_o && mst_ar_ready_i;
   assign pop       = mst_r_valid_i && slv_r_ready_i && mst_r_last_i && !empty;

   assign slv_ar_ready_o = (state_q == IDLE);
   assign mst_ar_valid_o = (state_q == SPLIT) && !full;
   assign mst_ar_addr_o  = addr_q;
   assign mst_ar_len_o   = 8'(n - 9'd1);
   assign mst_ar_size_o  = size_q;
   assign mst_ar_burst_o = burst_q;

   assign slv_r_valid_o = mst_r_valid_i;
   assign mst_r_ready_o = slv_r_ready_i;
   assign slv_r_data_o  = mst_r_data_i;
   assign slv_r_resp_o  = mst_r_resp_i;
   assign slv_r_last_o  = mst_r_last_i && !empty && final_q[rd_ptr_q];

   // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         size_q       <= '0;
         burst_q      <= '0;
         beats_left_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (slv_ar_hs) begin
               addr_q       <= slv_ar_addr_i;
               size_q       <= slv_ar_size_i;
               burst_q      <= slv_ar_burst_i;
               beats_left_q <= {1'b0, slv_ar_len_i} + 9'd1;
               state_q      <= SPLIT;
            end
            SPLIT: if (push) begin
               addr_q       <= next_addr;
               beats_left_q <= beats_left_q - n;
               if (is_final) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // NOTE: the tracking FIFO is a few flops, so it is reset along with its pointers to drop stale entries.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         final_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            final_q[wr_ptr_q] <= is_final;
            wr_ptr_q          <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef VLSU_AR_SPLIT_STATS_EN
   logic first_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         first_q    <= 1'b0;
         nr_split_o <= '0;
      end else begin
         if (slv_ar_hs) first_q <= 1'b1;
         else if (push) first_q <= 1'b0;
         if (push && first_q && !is_final && (nr_split_o != '1))
            nr_split_o <= nr_split_o + 32'd1;
      end
   end
`endif

   r_valid_needs_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
      mst_r_valid_i |-> !empty);

endmodule

// File: tb/tb_vlsu_ar_splitter.sv
// Bench for vlsu_ar_splitter: directed and random requests checked against a burst-list reference model.
// Checks nr_split_o as well when VLSU_AR_SPLIT_STATS_EN is defined.
module tb_vlsu_ar_splitter;

   localparam int AW   = 64;
   localparam int DW   = 128;
   localparam int MAXB = 16;
   localparam int NOUT = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic [AW-1:0] slv_ar_addr_i;
   logic [7:0]    slv_ar_len_i;
   logic [2:0]    slv_ar_size_i;
   logic [1:0]    slv_ar_burst_i;
   logic          slv_ar_valid_i;
   logic          slv_ar_ready_o;
   logic [AW-1:0] mst_ar_addr_o;
   logic [7:0]    mst_ar_len_o;
   logic [2:0]    mst_ar_size_o;
   logic [1:0]    mst_ar_burst_o;
   logic          mst_ar_valid_o;
   logic          mst_ar_ready_i;
   logic [DW-1:0] mst_r_data_i;
   logic [1:0]    mst_r_resp_i;
   logic          mst_r_last_i;
   logic          mst_r_valid_i;
   logic          mst_r_ready_o;
   logic [DW-1:0] slv_r_data_o;
   logic [1:0]    slv_r_resp_o;
   logic          slv_r_last_o;
   logic          slv_r_valid_o;
   logic          slv_r_ready_i;
`ifdef VLSU_AR_SPLIT_STATS_EN
   logic [31:0]   nr_split_o;
`endif

   vlsu_ar_splitter #(.AxiAddrWidth(AW), .AxiDataWidth(DW), .MaxBeats(MAXB), .NrOutstanding(NOUT)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .slv_ar_addr_i(slv_ar_addr_i), .slv_ar_len_i(slv_ar_len_i), .slv_ar_size_i(slv_ar_size_i),
      .slv_ar_burst_i(slv_ar_burst_i), .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
      .mst_ar_addr_o(mst_ar_addr_o), .mst_ar_len_o(mst_ar_len_o), .mst_ar_size_o(mst_ar_size_o),
      .mst_ar_burst_o(mst_ar_burst_o), .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
      .mst_r_data_i(mst_r_data_i), .mst_r_resp_i(mst_r_resp_i), .mst_r_last_i(mst_r_last_i),
      .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o),
      .slv_r_data_o(slv_r_data_o), .slv_r_resp_o(slv_r_resp_o), .slv_r_last_o(slv_r_last_o),
      .slv_r_valid_o(slv_r_valid_o),
`ifdef VLSU_AR_SPLIT_STATS_EN
      .nr_split_o(nr_split_o),
`endif
      .slv_r_ready_i(slv_r_ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  len;
      bit          fin;
   } sub_t;

   sub_t exp_q[$];   // sub-bursts still to be issued on AR
   sub_t out_q[$];   // issued sub-bursts awaiting their R beats
   int   total = 0;
   int   bad   = 0;
   int   split_cnt = 0;
   logic [2:0] cur_size;
   logic [1:0] cur_burst;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: walk the request beat budget, cutting at MaxBeats and page ends.
   task automatic model(input logic [63:0] a, input int len, input int size, input int burst);
      logic [63:0] addr = a;
      int left = len + 1;
      int n, page;
      exp_q.delete();
      while (left > 0) begin
         if (burst == 1) begin
            page = (4096 - int'(addr % 64'd4096)) >> size;
            if (page < 1) page = 1;
            n = left;
            if (n > MAXB) n = MAXB;
            if (n > page) n = page;
         end else begin
            n = left;
         end
         exp_q.push_back('{addr: addr, len: 8'(n - 1), fin: (left == n)});
         addr = ((addr >> size) << size) + (64'(n) << size);
         left -= n;
      end
   endtask

   task automatic run_request(input logic [63:0] a, input int len, input int size, input int burst,
                              input int ar_pct, input int r_pct, input int hold);
      int  cyc = 0, beat = 0, ar_cnt = 0;
      bit  ar_hs, r_hs, exp_last;
      @(negedge clk_i);
      slv_ar_addr_i  = a;
      slv_ar_len_i   = 8'(len);
      slv_ar_size_i  = 3'(size);
      slv_ar_burst_i = 2'(burst);
      slv_ar_valid_i = 1'b1;
      #1;
      check("req_ready", slv_ar_ready_o, 1'b1);
      check("idle_no_ar", mst_ar_valid_o, 1'b0);
      @(negedge clk_i);
      slv_ar_valid_i = 1'b0;
      cur_size  = 3'(size);
      cur_burst = 2'(burst);
      model(a, len, size, burst);
      if (exp_q.size() > 1) split_cnt++;
      while ((exp_q.size() > 0 || out_q.size() > 0) && cyc < 4000) begin
         mst_ar_ready_i = ($urandom_range(99) < ar_pct);
         slv_r_ready_i  = ($urandom_range(99) < r_pct);
         if (out_q.size() > 0 && cyc >= hold && ($urandom_range(99) < r_pct)) begin
            mst_r_valid_i = 1'b1;
            mst_r_last_i  = (beat == int'(out_q[0].len));
            mst_r_data_i  = {$urandom, $urandom, $urandom, $urandom};
            mst_r_resp_i  = 2'($urandom);
         end else begin
            mst_r_valid_i = 1'b0;
            mst_r_last_i  = 1'b0;
         end
         #1;
         check("ar_valid", mst_ar_valid_o, (exp_q.size() > 0 && out_q.size() < NOUT));
         check("slv_ar_ready", slv_ar_ready_o, (exp_q.size() == 0));
         if (mst_ar_valid_o && exp_q.size() > 0) begin
            check("ar_addr", mst_ar_addr_o, exp_q[0].addr);
            check("ar_len", mst_ar_len_o, exp_q[0].len);
            check("ar_size", mst_ar_size_o, cur_size);
            check("ar_burst", mst_ar_burst_o, cur_burst);
         end
         exp_last = mst_r_valid_i && mst_r_last_i && out_q.size() > 0 && out_q[0].fin;
         check("r_valid", slv_r_valid_o, mst_r_valid_i);
         check("r_ready", mst_r_ready_o, slv_r_ready_i);
         check("r_last", slv_r_last_o, exp_last);
         if (mst_r_valid_i) begin
            check("r_data", slv_r_data_o, mst_r_data_i);
            check("r_resp", slv_r_resp_o, mst_r_resp_i);
         end
         if (hold > 0 && cyc == hold) check("holdoff_ar_count", ar_cnt, NOUT);
         ar_hs = mst_ar_valid_o && mst_ar_ready_i && exp_q.size() > 0;
         r_hs  = mst_r_valid_i && slv_r_ready_i;
         @(posedge clk_i);
         if (r_hs) begin
            if (mst_r_last_i) begin
               void'(out_q.pop_front());
               beat = 0;
            end else begin
               beat++;
            end
         end
         if (ar_hs) begin
            out_q.push_back(exp_q.pop_front());
            ar_cnt++;
         end
         @(negedge clk_i);
         cyc++;
      end
      check("drained", exp_q.size() + out_q.size(), 0);
      mst_r_valid_i  = 1'b0;
      mst_r_last_i   = 1'b0;
      mst_ar_ready_i = 1'b0;
   endtask

   initial begin
      rst_ni = 1'b0;
      slv_ar_addr_i = '0; slv_ar_len_i = '0; slv_ar_size_i = '0; slv_ar_burst_i = '0;
      slv_ar_valid_i = 1'b0; mst_ar_ready_i = 1'b0; mst_r_data_i = '0; mst_r_resp_i = '0;
      mst_r_last_i = 1'b0; mst_r_valid_i = 1'b0; slv_r_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("rst_slv_ar_ready", slv_ar_ready_o, 1'b1);
      check("rst_mst_ar_valid", mst_ar_valid_o, 1'b0);
      check("rst_r_last", slv_r_last_o, 1'b0);
`ifdef VLSU_AR_SPLIT_STATS_EN
      check("rst_nr_split", nr_split_o, 32'd0);
`endif
      rst_ni = 1'b1;

      run_request(64'h1000, 7, 4, 1, 100, 100, 0);
      run_request(64'h0, 63, 3, 1, 100, 100, 0);
      run_request(64'hFC0, 7, 4, 1, 70, 80, 0);
      run_request(64'h0, 127, 3, 1, 100, 100, 20);
      run_request(64'h20, 31, 3, 0, 100, 100, 0);
      run_request(64'hFFF, 3, 7, 1, 80, 80, 0);
      for (int i = 0; i < 25; i++) begin
         logic [63:0] ra;
         ra = {$urandom, $urandom};
         if (i % 3 == 0) ra[11:0] = 12'hF00 | 12'($urandom_range(255));
         run_request(ra, $urandom_range(255), $urandom_range(7), $urandom_range(1), 75, 75, 0);
      end
`ifdef VLSU_AR_SPLIT_STATS_EN
      check("nr_split", nr_split_o, 32'(split_cnt));
`endif

      // Reset while the second sub-burst of a split request is pending.
      @(negedge clk_i);
      slv_ar_addr_i = 64'h0; slv_ar_len_i = 8'd63; slv_ar_size_i = 3'd3; slv_ar_burst_i = 2'd1;
      slv_ar_valid_i = 1'b1;
      @(negedge clk_i);
      slv_ar_valid_i = 1'b0;
      mst_ar_ready_i = 1'b1;
      @(negedge clk_i);
      mst_ar_ready_i = 1'b0;
      #1;
      check("mid_second_valid", mst_ar_valid_o, 1'b1);
      check("mid_second_addr", mst_ar_addr_o, 64'h80);
      rst_ni = 1'b0;
      #1;
      check("midrst_ar_valid", mst_ar_valid_o, 1'b0);
      check("midrst_slv_ready", slv_ar_ready_o, 1'b1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      exp_q.delete();
      out_q.delete();
      split_cnt = 0;
`ifdef VLSU_AR_SPLIT_STATS_EN
      check("midrst_nr_split", nr_split_o, 32'd0);
`endif
      run_request(64'h40, 0, 3, 1, 100, 100, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
